unidade_controle_jogada: RTL

//  Moore FSM that sequences one round of user plays against the stored sequence.

---
 rtl/unidade_controle_jogada_pkg.sv | 31 +++
 rtl/unidade_controle_jogada_detector_borda.sv | 22 ++
 rtl/unidade_controle_jogada.sv | 130 +++++++++++++
 3 files changed

// File: rtl/unidade_controle_jogada_pkg.sv
// Shared state codes and types for the play-sequencing controller.
// The codes double as the db_estado debug value.
package unidade_controle_jogada_pkg;

    localparam logic [3:0] ST_INICIAL  = 4'h0;
    localparam logic [3:0] ST_PREPARA  = 4'h1;
    localparam logic [3:0] ST_ESPERA   = 4'h2;
    localparam logic [3:0] ST_REGISTRA = 4'h4;
    localparam logic [3:0] ST_COMPARA  = 4'h5;
    localparam logic [3:0] ST_PROXIMO  = 4'h6;
    localparam logic [3:0] ST_FIM_OK   = 4'hA;
    localparam logic [3:0] ST_FIM_TMO  = 4'hD;
    localparam logic [3:0] ST_FIM_ERR  = 4'hE;

    typedef enum logic [3:0] {
        INICIAL  = ST_INICIAL,
        PREPARA  = ST_PREPARA,
        ESPERA   = ST_ESPERA,
        REGISTRA = ST_REGISTRA,
        COMPARA  = ST_COMPARA,
        PROXIMO  = ST_PROXIMO,
        FIM_OK   = ST_FIM_OK,
        FIM_TMO  = ST_FIM_TMO,
        FIM_ERR  = ST_FIM_ERR
    } estado_t;

    function automatic logic is_fim(input estado_t e);
        return (e == FIM_OK) || (e == FIM_ERR) || (e == FIM_TMO);
    endfunction

endpackage

// File: rtl/unidade_controle_jogada_detector_borda.sv
// Rising-edge detector; history resets high so a level
// already asserted at reset release produces no pulse.
module detector_borda (
    input  logic clock,
    input  logic reset,
    input  logic sinal,
    output logic pulso
);

    logic r_hist;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hist <= 1'b1;
        end else begin
            r_hist <= sinal;
        end
    end

    assign pulso = sinal & ~r_hist;

endmodule

// File: rtl/unidade_controle_jogada.sv
// Moore controller for one round of plays: clears/steps the
// address counter, strobes the play register, flags the result.
module unidade_controle_jogada
    import unidade_controle_jogada_pkg::*;
#(
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 5000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              jogada,
    input  logic              igual,
    input  logic [ADDR_W-1:0] endereco,
    output logic              cnt_clr_n,
    output logic              cnt_ld_n,
    output logic              cnt_en,
    output logic              reg_load,
    output logic              pronto,
    output logic              acertou,
    output logic              errou,
    output logic              timeout,
    output logic [3:0]        db_estado
);

    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] END_LAST = '1;

    estado_t          r_estado;
    estado_t          w_prox;
    logic [TMR_W-1:0] r_timer;
    logic             w_borda;
    logic             w_tmo;
    logic             w_fim_hold;

    detector_borda u_borda (
        .clock (clock),
        .reset (reset),
        .sinal (jogada),
        .pulso (w_borda)
    );

    assign w_tmo      = (r_timer == TMR_LAST);
    assign w_fim_hold = is_fim(r_estado) && !iniciar;

    always_comb begin
        w_prox = INICIAL;
        case (r_estado)
            INICIAL:  w_prox = iniciar ? PREPARA : INICIAL;
            PREPARA:  w_prox = ESPERA;
            ESPERA: begin
                // a press in the last cycle still counts
                if (w_borda) begin
                    w_prox = REGISTRA;
                end else if (w_tmo) begin
                    w_prox = FIM_TMO;
                end else begin
                    w_prox = ESPERA;
                end
            end
            REGISTRA: w_prox = COMPARA;
            COMPARA: begin
                if (!igual) begin
                    w_prox = FIM_ERR;
                end else if (endereco == END_LAST) begin
                    w_prox = FIM_OK;
                end else begin
                    w_prox = PROXIMO;
                end
            end
            PROXIMO:  w_prox = ESPERA;
            FIM_OK,
            FIM_ERR,
            FIM_TMO:  w_prox = w_fim_hold ? r_estado : PREPARA;
            default:  w_prox = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_prox;
        end
    end

    // saturating; only meaningful while in ESPERA
    always_ff @(posedge clock) begin
        if (reset) begin
            r_timer <= '0;
        end else if (r_estado == PREPARA || r_estado == PROXIMO) begin
            r_timer <= '0;
        end else if (r_estado == ESPERA && r_timer != '1) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_comb begin
        cnt_clr_n = 1'b1;
        cnt_ld_n  = 1'b1;
        cnt_en    = 1'b0;
        reg_load  = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        case (r_estado)
            PREPARA:  cnt_clr_n = 1'b0;
            REGISTRA: reg_load  = 1'b1;
            PROXIMO:  cnt_en    = 1'b1;
            FIM_OK: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_ERR: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            FIM_TMO: begin
                pronto  = 1'b1;
                timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = r_estado;

endmodule
